// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and FSM state encoding for the digit-serial BCD subtractor.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_sub.sv
// bcd_digit_sub: combinational one-digit BCD subtract with borrow in/out.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout
);

  // 5-bit two's complement holds -10..9; bit 4 is the sign
  logic [DIGIT_W:0] t;

  always_comb begin
    t    = {1'b0, x} - {1'b0, y} - {{DIGIT_W{1'b0}}, bin};
    bout = t[DIGIT_W];
    d    = t[DIGIT_W] ? (t[DIGIT_W-1:0] + 4'd10) : t[DIGIT_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/bcd_sub_serial.sv
// bcd_sub_serial: digit-serial |a - b| in BCD, LSD first, with sign and invalid-digit flags.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module bcd_sub_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  neg,
  output logic                  err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  state_t state, state_nx;

  logic [DIGITS-1:0][DIGIT_W-1:0] a_q, b_q, diff_q;
  logic [IDX_W-1:0]               idx;
  logic                           borrow;
  logic                           invalid;
  logic                           is_last;
  logic [DIGIT_W-1:0]             x, y, d;
  logic                           bout;

  // Operands are stable after load, so the range check can run on the latched copy
  always_comb begin
    invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a_q[i] > BCD_MAX || b_q[i] > BCD_MAX) invalid = 1'b1;
    end
  end

  assign is_last = (idx == LAST);

  // One digit slice serves both the subtract pass and the ten's-complement pass
  always_comb begin
    x = a_q[idx];
    y = b_q[idx];
    if (state == NEG) begin
      x = '0;
      y = diff_q[idx];
    end
  end

  bcd_digit_sub u_digit (
    .x    (x),
    .y    (y),
    .bin  (borrow),
    .d    (d),
    .bout (bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = SUB;
      SUB: begin
        if (invalid)      state_nx = DONE;
        else if (is_last) state_nx = bout ? NEG : DONE;
      end
      NEG:  if (is_last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      neg    <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            diff_q <= '0;
            idx    <= '0;
            borrow <= 1'b0;
            neg    <= 1'b0;
            err    <= 1'b0;
          end
        end
        SUB, NEG: begin
          if (state == SUB && invalid) begin
            err <= 1'b1;
          end else begin
            diff_q[idx] <= d;
            if (is_last) begin
              borrow <= 1'b0;
              idx    <= '0;
              if (state == NEG) neg <= 1'b1;
            end else begin
              borrow <= bout;
              idx    <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign diff = diff_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_sub_serial.sv
// tb_bcd_sub_serial: directed vectors with hand-computed results for bcd_sub_serial (DIGITS=4).
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_bcd_sub_serial;

  localparam int DIGITS = 4;

  logic                clk;
  logic                rst;
  logic                start;
  logic [4*DIGITS-1:0] a;
  logic [4*DIGITS-1:0] b;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] diff;
  logic                neg;
  logic                err;

  int n_checks;
  int n_fail;

  bcd_sub_serial #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .neg   (neg),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Issue one operation; hold keeps start high for that many edges after edge 0
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input int hold, input logic [15:0] exp_diff, input logic exp_neg,
                        input logic exp_err, input int exp_lat);
    int k;
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (hold == 0) start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
      if (k >= hold) start = 1'b0;
    end while (!done && k < 40);
    check({tag, "_lat"}, 32'(k), 32'(exp_lat));
    check({tag, "_diff"}, 32'(diff), 32'(exp_diff));
    check({tag, "_neg"}, 32'(neg), 32'(exp_neg));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold_diff"}, 32'(diff), 32'(exp_diff));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_neg",  32'(neg),  32'd0);
    check("rst_err",  32'(err),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("pos",     16'h0042, 16'h0017, 0, 16'h0025, 1'b0, 1'b0, 4);
    run_op("negv",    16'h0017, 16'h0042, 0, 16'h0025, 1'b1, 1'b0, 8);
    run_op("chain",   16'h1000, 16'h0001, 0, 16'h0999, 1'b0, 1'b0, 4);
    run_op("equal",   16'h9999, 16'h9999, 0, 16'h0000, 1'b0, 1'b0, 4);
    run_op("zm1",     16'h0000, 16'h0001, 0, 16'h0001, 1'b1, 1'b0, 8);
    run_op("bad_a",   16'h00A3, 16'h0000, 0, 16'h0000, 1'b0, 1'b1, 1);
    run_op("bad_b",   16'h0001, 16'h000F, 0, 16'h0000, 1'b0, 1'b1, 1);
    run_op("hold",    16'h0500, 16'h0250, 3, 16'h0250, 1'b0, 1'b0, 4);

    // Abort an operation midway with an asynchronous reset
    @(negedge clk);
    a     = 16'h0500;
    b     = 16'h0250;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_diff", 32'(diff), 32'd0);
    check("mid_neg",  32'(neg),  32'd0);
    check("mid_err",  32'(err),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("after_rst", 16'h0009, 16'h0003, 0, 16'h0006, 1'b0, 1'b0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
